// File: rtl/obstacle_scheduler_if.sv
// obstacle_scheduler_if : handshake/bus bundle between the game FSM (master)
// and the obstacle scheduler (slave).
//   start           master->slave  1-cycle begin/restart pulse
//   pause           master->slave  stall RUN (only when PAUSE_EN is defined)
//   player_pos      master->slave  one-hot player column on bottom row
//   bottom_row      master->slave  registered bottom row of the board
//   update_obstacle slave->master  1-cycle shift/load pulse
//   row_data        slave->master  row inserted at top on update_obstacle
//   board_clear     slave->master  1-cycle board wipe
//   game_Over       slave->master  held game-over flag
//   level / score   slave->master  display counters
interface obstacle_scheduler_if #(
  parameter int board_width = 9
) ();
  logic                   start;
`ifdef PAUSE_EN
  logic                   pause;
`endif
  logic [board_width-1:0] player_pos;
  logic [board_width-1:0] bottom_row;
  logic                   update_obstacle;
  logic [board_width-1:0] row_data;
  logic                   board_clear;
  logic                   game_Over;
  logic [3:0]             level;
  logic [15:0]            score;

  modport master (
`ifdef PAUSE_EN
    output pause,
`endif
    output start, player_pos, bottom_row,
    input  update_obstacle, row_data, board_clear, game_Over, level, score
  );

  modport slave (
`ifdef PAUSE_EN
    input  pause,
`endif
    input  start, player_pos, bottom_row,
    output update_obstacle, row_data, board_clear, game_Over, level, score
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler : paces board shifts from a programmable tick, generates
// always-passable top rows from a 16-bit Galois LFSR, detects player/obstacle
// collision on the bottom row and speeds play up by level.
// Ports:
//   clk    system clock (posedge)
//   reset  asynchronous, active-low
//   bus    obstacle_scheduler_if.slave (start/pause/player_pos/bottom_row in;
//          update_obstacle/row_data/board_clear/game_Over/level/score out)
// Config macro: PAUSE_EN adds bus.pause; when undefined RUN never stalls.
module obstacle_scheduler #(
  parameter int board_width    = 9,
  parameter int board_height   = 16,
  parameter int tick_width     = 26,
  parameter int init_period    = 25000000,
  parameter int min_period     = 5000000,
  parameter int period_step    = 2500000,
  parameter int rows_per_level = 16
) (
  input logic                  clk,
  input logic                  reset,
  obstacle_scheduler_if.slave  bus
);

  localparam logic [tick_width-1:0] INIT_P   = tick_width'(init_period);
  localparam logic [tick_width-1:0] TICK0    = tick_width'(init_period - 1);
  localparam logic [tick_width-1:0] MIN_P    = tick_width'(min_period);
  localparam logic [tick_width:0]   STEP_P   = (tick_width+1)'(period_step);
  localparam logic [tick_width-1:0] T_ONE    = tick_width'(1);
  localparam logic [15:0]           RPL_LAST = 16'(rows_per_level - 1);
  // Rows come from a 16-bit LFSR and the board needs a real bottom row;
  // an unsupported geometry simply never leaves IDLE.
  localparam bit CFG_OK = (board_height >= 2) && (board_width <= 16);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t                 state_q, state_d;
  logic [tick_width-1:0]  tick_q, tick_d, period_q, period_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   gap_q, gap_d;
  logic [board_width-1:0] row_q, row_d;
  logic [15:0]            rcnt_q, rcnt_d;
  logic [3:0]             level_q, level_d;
  logic [15:0]            score_q, score_d;
  logic                   over_q, over_d;
  logic                   upd_q, upd_d;

  logic                   pause_w;
  logic                   start_acc, hit;
  logic [15:0]            lfsr_nxt;
  logic [board_width-1:0] row_cand;
  int                     clr_idx;
  logic [tick_width:0]    per_diff;
  logic [tick_width-1:0]  per_dec;

`ifdef PAUSE_EN
  assign pause_w = bus.pause;
`else
  assign pause_w = 1'b0;
`endif

  assign start_acc = bus.start && (state_q != RUN) && CFG_OK;
  assign hit       = |(bus.bottom_row & bus.player_pos);

  // Galois, taps 16,14,13,11 -> mask 0xB400 on a right shift
  assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Wide subtraction so a large step can't wrap below the floor
  assign per_diff = {1'b0, period_q} - STEP_P;
  assign per_dec  = (per_diff[tick_width] || (per_diff[tick_width-1:0] < MIN_P))
                    ? MIN_P : per_diff[tick_width-1:0];

  // Obstacle rows alternate with empty rows; a full row gets one hole punched
  always_comb begin
    row_cand = gap_q ? '0 : lfsr_q[board_width-1:0];
    clr_idx  = int'(lfsr_q[3:0]) % board_width;
    if (&row_cand)
      for (int i = 0; i < board_width; i++)
        if (i == clr_idx) row_cand[i] = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    period_d = period_q;
    lfsr_d   = lfsr_q;
    gap_d    = gap_q;
    row_d    = row_q;
    rcnt_d   = rcnt_q;
    level_d  = level_q;
    score_d  = score_q;
    over_d   = over_q;
    upd_d    = 1'b0;

    unique case (state_q)
      IDLE:    if (start_acc) state_d = RUN;
      RUN:     if (hit)       state_d = OVER;
      OVER:    if (start_acc) state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (start_acc) begin
      level_d  = '0;
      score_d  = '0;
      gap_d    = 1'b0;
      rcnt_d   = '0;
      period_d = INIT_P;
      tick_d   = TICK0;
      over_d   = 1'b0;
    end else if (state_q == RUN) begin
      // collision beats a same-cycle tick expiry
      if (hit) begin
        over_d = 1'b1;
      end else if (!pause_w) begin
        if (tick_q == '0) begin
          upd_d  = 1'b1;
          row_d  = row_cand;
          lfsr_d = lfsr_nxt;
          gap_d  = ~gap_q;
          tick_d = period_q - T_ONE;   // reload uses the pre-speed-up period
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          if (rcnt_q == RPL_LAST) begin
            rcnt_d   = '0;
            period_d = per_dec;
            if (level_q != 4'hF) level_d = level_q + 4'd1;
          end else begin
            rcnt_d = rcnt_q + 16'd1;
          end
        end else begin
          tick_d = tick_q - T_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      tick_q   <= TICK0;
      period_q <= INIT_P;
      lfsr_q   <= 16'hACE1;
      gap_q    <= 1'b0;
      row_q    <= '0;
      rcnt_q   <= '0;
      level_q  <= '0;
      score_q  <= '0;
      over_q   <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      period_q <= period_d;
      lfsr_q   <= lfsr_d;
      gap_q    <= gap_d;
      row_q    <= row_d;
      rcnt_q   <= rcnt_d;
      level_q  <= level_d;
      score_q  <= score_d;
      over_q   <= over_d;
      upd_q    <= upd_d;
    end
  end

  // board_clear is combinational so the board wipes in the start cycle itself
  assign bus.board_clear     = start_acc && reset;
  assign bus.update_obstacle = upd_q;
  assign bus.row_data        = row_q;
  assign bus.game_Over       = over_q;
  assign bus.level           = level_q;
  assign bus.score           = score_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler : randomized + directed bench for obstacle_scheduler
// against a behavioural model (update count drives level/score/period).
module tb_obstacle_scheduler;
  localparam int BW   = 9;
  localparam int INIT = 4;
  localparam int MINP = 2;
  localparam int STEP = 1;
  localparam int RPL  = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  obstacle_scheduler_if #(.board_width(BW)) bus ();

  obstacle_scheduler #(
    .board_width(BW), .board_height(16), .tick_width(26),
    .init_period(INIT), .min_period(MINP), .period_step(STEP),
    .rows_per_level(RPL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_mode, m_count, m_updates;
  logic [15:0] m_lfsr;
  bit         m_gap, m_upd, m_over;
  logic [8:0] m_row;
  bit         m_paused;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [8:0] gen_row(input logic [15:0] s, input bit gap);
    logic [8:0] r;
    r = gap ? 9'h000 : s[8:0];
    if (r == 9'h1FF) r[int'(s[3:0]) % 9] = 1'b0;
    return r;
  endfunction

  // period in force for the reload that follows update number k
  function automatic int period_after(input int k);
    int p;
    p = INIT - STEP * ((k - 1) / RPL);
    return (p < MINP) ? MINP : p;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_count = INIT - 1; m_updates = 0;
      m_lfsr = 16'hACE1; m_gap = 0; m_upd = 0; m_over = 0; m_row = '0;
    end else begin
`ifdef PAUSE_EN
      m_paused = bus.pause;
`else
      m_paused = 0;
`endif
      m_upd = 0;
      if (m_mode != M_RUN) begin
        if (bus.start) begin
          m_mode = M_RUN; m_count = INIT - 1; m_updates = 0; m_gap = 0; m_over = 0;
        end
      end else if (|(bus.bottom_row & bus.player_pos)) begin
        m_mode = M_OVER; m_over = 1;
      end else if (!m_paused) begin
        if (m_count == 0) begin
          m_upd = 1;
          m_row = gen_row(m_lfsr, m_gap);
          m_lfsr = lfsr_step(m_lfsr);
          m_gap = !m_gap;
          m_updates++;
          m_count = period_after(m_updates) - 1;
        end else begin
          m_count--;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int lv, sc;
    lv = m_updates / RPL; if (lv > 15) lv = 15;
    sc = m_updates;       if (sc > 65535) sc = 65535;
    chk("update_obstacle", 32'(bus.update_obstacle), 32'(m_upd));
    chk("row_data",        32'(bus.row_data),        32'(m_row));
    chk("board_clear",     32'(bus.board_clear),     32'(reset && bus.start && m_mode != M_RUN));
    chk("game_Over",       32'(bus.game_Over),       32'(m_over));
    chk("level",           32'(bus.level),           32'(lv));
    chk("score",           32'(bus.score),           32'(sc));
    if (bus.update_obstacle) chk("row_not_full", 32'(bus.row_data == 9'h1FF), 32'(0));
  end

  // ---------------- directed helpers ----------------
  task automatic wait_pulse(output int n, input int budget);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.update_obstacle && n < budget);
    if (!bus.update_obstacle) begin
      n_cmp++; n_bad++;
      $display("FAIL pulse_timeout: none within %0d cycles", budget);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(negedge clk); chk("board_clear_on_start", 32'(bus.board_clear), 32'(1));
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk); chk("board_clear_1cyc", 32'(bus.board_clear), 32'(0));
    chk("game_over_cleared", 32'(bus.game_Over), 32'(0));
  endtask

  function automatic logic [8:0] onehot(input int c);
    logic [8:0] v;
    v = 9'h001;
    return v << c;
  endfunction

  initial begin
    int n, pc, g;
    int gaps[6];
    logic [8:0] rows3[3];
    gaps  = '{4, 4, 4, 3, 3, 2};
    rows3 = '{9'h0E1, 9'h000, 9'h138};
    bus.start = 1'b0; bus.player_pos = 9'h001; bus.bottom_row = 9'h000;
`ifdef PAUSE_EN
    bus.pause = 1'b0;
`endif
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // idle after reset: nothing moves
    pc = 0;
    repeat (20) begin @(negedge clk); pc += int'(bus.update_obstacle); end
    chk("idle_pulses", 32'(pc), 32'(0));
    chk("idle_level", 32'(bus.level), 32'(0));
    chk("idle_score", 32'(bus.score), 32'(0));

    // first game: pacing, rows, speed-up
    do_start();
    for (int k = 0; k < 6; k++) begin
      wait_pulse(n, 20);
      chk($sformatf("gap%0d", k), 32'(n), 32'(gaps[k]));
      if (k < 3) chk($sformatf("row%0d", k), 32'(bus.row_data), 32'(rows3[k]));
    end
    chk("score_6", 32'(bus.score), 32'(6));
    chk("level_3", 32'(bus.level), 32'(3));

    // collision ends the game and freezes counters
    @(posedge clk); #1 bus.bottom_row = 9'h001;
    @(posedge clk); #1 bus.bottom_row = 9'h000;
    @(negedge clk); chk("collide_over", 32'(bus.game_Over), 32'(1));
    pc = 0;
    repeat (12) begin @(negedge clk); pc += int'(bus.update_obstacle); end
    chk("over_pulses", 32'(pc), 32'(0));
    chk("over_score", 32'(bus.score), 32'(6));
    chk("over_level", 32'(bus.level), 32'(3));

    // restart from OVER
    do_start();
    chk("restart_level", 32'(bus.level), 32'(0));
    chk("restart_score", 32'(bus.score), 32'(0));
    wait_pulse(n, 20);
    chk("restart_gap", 32'(n), 32'(4));

    // collision on the tick==0 cycle suppresses the pulse
    g = 0;
    do begin @(posedge clk); #1; g++; end while (m_count != 0 && g < 20);
    bus.bottom_row = 9'h001;
    @(posedge clk); #1 bus.bottom_row = 9'h000;
    @(negedge clk);
    chk("tie_no_pulse", 32'(bus.update_obstacle), 32'(0));
    chk("tie_score", 32'(bus.score), 32'(1));
    chk("tie_over", 32'(bus.game_Over), 32'(1));

    do_start();
`ifdef PAUSE_EN
    wait_pulse(n, 20);
    @(posedge clk); #1 bus.pause = 1'b1;
    pc = 0;
    repeat (10) begin @(negedge clk); pc += int'(bus.update_obstacle); end
    @(posedge clk); #1 bus.pause = 1'b0;
    chk("pause_pulses", 32'(pc), 32'(0));
    chk("pause_score", 32'(bus.score), 32'(1));
    wait_pulse(n, 20);
    chk("pause_resume_gap", 32'(n), 32'(4));
`endif

    // async reset mid-run
    wait_pulse(n, 20);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("rst_update", 32'(bus.update_obstacle), 32'(0));
    chk("rst_row",    32'(bus.row_data), 32'(0));
    chk("rst_over",   32'(bus.game_Over), 32'(0));
    chk("rst_level",  32'(bus.level), 32'(0));
    chk("rst_score",  32'(bus.score), 32'(0));
    @(posedge clk); #1 reset = 1'b1;

    // long collision-free game: level must saturate
    do_start();
    repeat (600) begin
      @(posedge clk); #1;
      bus.player_pos = onehot($urandom_range(0, 8));
      bus.bottom_row = 9'($urandom) & ~bus.player_pos;
`ifdef PAUSE_EN
      bus.pause = ($urandom_range(0, 7) == 0);
`endif
    end
    @(negedge clk);
    chk("level_sat", 32'(bus.level), 32'(15));

    // fully random traffic
    repeat (3000) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
      end
      bus.player_pos = onehot($urandom_range(0, 8));
      bus.bottom_row = 9'($urandom) & ~bus.player_pos;
      if ($urandom_range(0, 19) == 0) bus.bottom_row = bus.bottom_row | bus.player_pos;
      bus.start = ($urandom_range(0, 29) == 0);
`ifdef PAUSE_EN
      bus.pause = ($urandom_range(0, 3) == 0);
`endif
    end
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
